bist_controller: RTL

Sequencing and signature stage for the per-scan BIST path. On `start` it clears the pattern LFSR, alternates shift and capture phases of the scan chain for a fixed number of patterns, and compacts the chain's serial `scan_out` stream into a 16-bit signature. It then compares that signature against a golden value and reports pass/fail. It sits upstream of the LFSR and scan chain, driving their `mode` and clear, and downstream of the chain, consuming `scan_out`.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_controller_if.sv | 22 ++
 rtl/bist_controller_sisr.sv | 22 ++
 rtl/bist_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer and its signature register.
// The SISR step function is also used by the controller to form the pass flag.
package bist_pkg;
  localparam int SIG_WIDTH = 16;
  localparam logic [SIG_WIDTH-1:0] SISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  // One serial step of x^16+x^12+x^5+1 compaction.
  function automatic logic [SIG_WIDTH-1:0] sisr_step(input logic [SIG_WIDTH-1:0] sig,
                                                    input logic din);
    logic fb;
    fb = sig[SIG_WIDTH-1] ^ din;
    return {sig[SIG_WIDTH-2:0], 1'b0} ^ (fb ? SISR_POLY : '0);
  endfunction
endpackage

// File: rtl/bist_controller_if.sv
// Signal bundle between the BIST controller and the scan/LFSR environment.
// master = controller side, slave = environment/bench side.
interface bist_controller_if;
  logic                          start;
  logic                          scan_out;
  logic                          mode;
  logic                          lfsr_clear;
  logic                          busy;
  logic                          done;
  logic                          pass;
  logic [bist_pkg::SIG_WIDTH-1:0] signature;

  modport master (
    input  start, scan_out,
    output mode, lfsr_clear, busy, done, pass, signature
  );

  modport slave (
    output start, scan_out,
    input  mode, lfsr_clear, busy, done, pass, signature
  );
endinterface

// File: rtl/bist_controller_sisr.sv
// Serial-input signature register; one compaction step per enabled cycle.
// clear has priority over enable; output is the register itself.
module sisr
  import bist_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 serial_in,
  output logic [SIG_WIDTH-1:0] signature
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= sisr_step(signature, serial_in);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: alternates shift/capture over NUM_PATTERNS patterns, compacts scan_out.
// done rises 1 + NUM_PATTERNS*(CHAIN_LENGTH+1) + CHAIN_LENGTH edges after start is sampled.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                   CHAIN_LENGTH     = 8,
  parameter int                   NUM_PATTERNS     = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIGNATURE = 16'h0000
) (
  input logic                clock,
  input logic                reset,
  bist_controller_if.master  bus
);

  localparam int SW = $clog2(CHAIN_LENGTH + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LENGTH - 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);

  state_t         state, state_nxt;
  logic [SW-1:0]  shift_cnt, shift_cnt_nxt;
  logic [PW-1:0]  pat_cnt, pat_cnt_nxt;
  logic           mode_nxt, clear_nxt, busy_nxt, done_nxt, pass_nxt;
  logic           sisr_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      shift_cnt      <= '0;
      pat_cnt        <= '0;
      bus.mode       <= 1'b0;
      bus.lfsr_clear <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
    end else begin
      state          <= state_nxt;
      shift_cnt      <= shift_cnt_nxt;
      pat_cnt        <= pat_cnt_nxt;
      bus.mode       <= mode_nxt;
      bus.lfsr_clear <= clear_nxt;
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      bus.pass       <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_cnt_nxt = shift_cnt;
    pat_cnt_nxt   = pat_cnt;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt     = INIT;
          shift_cnt_nxt = '0;
          pat_cnt_nxt   = '0;
        end
      end
      INIT: state_nxt = SHIFT;
      SHIFT, UNLOAD: begin
        if (shift_cnt == SHIFT_LAST) begin
          state_nxt     = (state == SHIFT) ? CAPTURE : DONE;
          shift_cnt_nxt = '0;
        end else begin
          shift_cnt_nxt = shift_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        pat_cnt_nxt = pat_cnt + 1'b1;
        state_nxt   = (pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they align with the state register.
  always_comb begin
    mode_nxt  = (state_nxt == SHIFT) || (state_nxt == UNLOAD);
    clear_nxt = (state_nxt == INIT);
    busy_nxt  = (state_nxt == INIT) || (state_nxt == SHIFT) ||
                (state_nxt == CAPTURE) || (state_nxt == UNLOAD);
    done_nxt  = (state_nxt == DONE);
    pass_nxt  = 1'b0;
    if (state == UNLOAD && state_nxt == DONE) begin
      pass_nxt = (sisr_step(bus.signature, bus.scan_out) == GOLDEN_SIGNATURE);
    end else if (state_nxt == DONE) begin
      pass_nxt = bus.pass;
    end
  end

  // The first shift only loads the chain; compaction begins after the first capture.
  assign sisr_en = bus.mode && (pat_cnt != '0);

  sisr u_sisr (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear_nxt),
    .enable    (sisr_en),
    .serial_in (bus.scan_out),
    .signature (bus.signature)
  );

endmodule
